// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter and sequencer sharing one single-port SRAM
// (sram_sim wrapper + macro) between two valid/ready requesters, with read
// responses steered back to the issuing port after READ_LATENCY cycles.
// Optional statistics counters: define SRAM_ARB_STATS_EN to enable them;
// otherwise the stat outputs are tied to zero and no counter flops exist.
module sram_arbiter #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned WMASK_WIDTH  = 2,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    // port 0
    input  logic                   p0_req_valid,
    output logic                   p0_req_ready,
    input  logic                   p0_we,
    input  logic [WMASK_WIDTH-1:0] p0_wmask,
    input  logic [ADDR_WIDTH-1:0]  p0_addr,
    input  logic [DATA_WIDTH-1:0]  p0_din,
    output logic                   p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]  p0_rsp_data,
    // port 1
    input  logic                   p1_req_valid,
    output logic                   p1_req_ready,
    input  logic                   p1_we,
    input  logic [WMASK_WIDTH-1:0] p1_wmask,
    input  logic [ADDR_WIDTH-1:0]  p1_addr,
    input  logic [DATA_WIDTH-1:0]  p1_din,
    output logic                   p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]  p1_rsp_data,
    // SRAM side
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    // statistics
    output logic [15:0]            stat_p0_grants,
    output logic [15:0]            stat_p1_grants,
    output logic [15:0]            stat_conflicts
);

    localparam int unsigned STAT_W = 16;
    localparam int unsigned LAST   = READ_LATENCY - 1;

    // last_grant_q = 1 means port 1 was granted last, so port 0 wins a tie
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [READ_LATENCY-1:0] tag_rd_q, tag_rd_d;
    logic [READ_LATENCY-1:0] tag_port_q, tag_port_d;
    logic                    gnt0_c, gnt1_c, accept_c;

    // Round-robin grant: a lone requester always wins, a tie goes to the other port
    always_comb begin
        gnt0_c   = p0_req_valid & (~p1_req_valid | last_grant_q);
        gnt1_c   = p1_req_valid & (~p0_req_valid | ~last_grant_q);
        accept_c = gnt0_c | gnt1_c;
    end

    assign p0_req_ready = gnt0_c;
    assign p1_req_ready = gnt1_c;

    // SRAM drive: granted fields on accept, otherwise quiet with held addr/din
    always_comb begin
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = addr_q;
        sram_din   = din_q;
        if (gnt0_c) begin
            sram_we    = p0_we;
            sram_wmask = p0_wmask;
            sram_addr  = p0_addr;
            sram_din   = p0_din;
        end else if (gnt1_c) begin
            sram_we    = p1_we;
            sram_wmask = p1_wmask;
            sram_addr  = p1_addr;
            sram_din   = p1_din;
        end
    end

    // Next-state for grant history, hold registers and read-tag shift pipeline
    always_comb begin
        last_grant_d  = accept_c ? gnt1_c : last_grant_q;
        addr_d        = sram_addr;
        din_d         = sram_din;
        tag_rd_d      = '0;
        tag_port_d    = '0;
        tag_rd_d[0]   = accept_c & ~sram_we;
        tag_port_d[0] = gnt1_c;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_rd_d[i]   = tag_rd_q[i-1];
            tag_port_d[i] = tag_port_q[i-1];
        end
    end

    // State registers; reset drops any in-flight read tags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            din_q        <= '0;
            tag_rd_q     <= '0;
            tag_port_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            tag_rd_q     <= tag_rd_d;
            tag_port_q   <= tag_port_d;
        end
    end

    // Response steering: last tag stage lines up with valid sram_dout
    always_comb begin
        p0_rsp_valid = tag_rd_q[LAST] & ~tag_port_q[LAST];
        p1_rsp_valid = tag_rd_q[LAST] &  tag_port_q[LAST];
        p0_rsp_data  = p0_rsp_valid ? sram_dout : '0;
        p1_rsp_data  = p1_rsp_valid ? sram_dout : '0;
    end

`ifdef SRAM_ARB_STATS_EN
    logic [STAT_W-1:0] p0_cnt_q, p0_cnt_d;
    logic [STAT_W-1:0] p1_cnt_q, p1_cnt_d;
    logic [STAT_W-1:0] conf_cnt_q, conf_cnt_d;

    // Saturating event counters
    always_comb begin
        p0_cnt_d   = p0_cnt_q;
        p1_cnt_d   = p1_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (gnt0_c && (p0_cnt_q != '1)) begin
            p0_cnt_d = p0_cnt_q + STAT_W'(1);
        end
        if (gnt1_c && (p1_cnt_q != '1)) begin
            p1_cnt_d = p1_cnt_q + STAT_W'(1);
        end
        if (p0_req_valid && p1_req_valid && (conf_cnt_q != '1)) begin
            conf_cnt_d = conf_cnt_q + STAT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p0_cnt_q   <= '0;
            p1_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            p0_cnt_q   <= p0_cnt_d;
            p1_cnt_q   <= p1_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign stat_p0_grants = p0_cnt_q;
    assign stat_p1_grants = p1_cnt_q;
    assign stat_conflicts = conf_cnt_q;
`else
    assign stat_p0_grants = '0;
    assign stat_p1_grants = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed + randomized bench for sram_arbiter against a
// transaction-level reference (grant rule, shadow memory, response queue).
// Honours SRAM_ARB_STATS_EN for the expected statistics values.
module tb_sram_arbiter;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned MW = 2;
    localparam int unsigned RL = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid;
    logic [MW-1:0] p0_wmask;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_din, p0_rsp_data;
    logic          p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid;
    logic [MW-1:0] p1_wmask;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_din, p1_rsp_data;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;
    logic [15:0]   stat_p0_grants, stat_p1_grants, stat_conflicts;

    // requester state
    logic          rq_v    [2];
    logic          rq_we   [2];
    logic [MW-1:0] rq_mask [2];
    logic [AW-1:0] rq_addr [2];
    logic [DW-1:0] rq_din  [2];

    assign p0_req_valid = rq_v[0];
    assign p0_we        = rq_we[0];
    assign p0_wmask     = rq_mask[0];
    assign p0_addr      = rq_addr[0];
    assign p0_din       = rq_din[0];
    assign p1_req_valid = rq_v[1];
    assign p1_we        = rq_we[1];
    assign p1_wmask     = rq_mask[1];
    assign p1_addr      = rq_addr[1];
    assign p1_din       = rq_din[1];

    sram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
        .p0_wmask(p0_wmask), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
        .p1_wmask(p1_wmask), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .stat_p0_grants(stat_p0_grants), .stat_p1_grants(stat_p1_grants),
        .stat_conflicts(stat_conflicts)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        for (int b = 0; b < int'(DW); b++) begin
            r[b] = mask[b / int'(DW / MW)] ? new_v[b] : old_v[b];
        end
        return r;
    endfunction

    // Environment SRAM: sram_sim input register followed by the macro
    logic [DW-1:0] mem [2**AW];
    logic          r_we    = 1'b0;
    logic [MW-1:0] r_wmask = '0;
    logic [AW-1:0] r_addr  = '0;
    logic [DW-1:0] r_din   = '0;
    initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    always @(posedge clock) begin
        r_we    <= sram_we;
        r_wmask <= sram_wmask;
        r_addr  <= sram_addr;
        r_din   <= sram_din;
        if (r_we) mem[r_addr] <= merge(mem[r_addr], r_din, r_wmask);
        else      sram_dout   <= mem[r_addr];
    end

    // Reference model state
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [2**AW];
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    int            m_g0, m_g1, m_conf;
    int            cyc;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = 1;
        m_addr = '0;
        m_din  = '0;
        m_g0   = 0;
        m_g1   = 0;
        m_conf = 0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [MW-1:0] mask,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        rq_v[p]    = 1'b1;
        rq_we[p]   = we;
        rq_mask[p] = mask;
        rq_addr[p] = addr;
        rq_din[p]  = din;
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // One cycle: check at negedge, update model, retire accepted request after edge
    task automatic step();
        int            g;
        logic          ev   [2];
        logic [DW-1:0] ed   [2];
        @(negedge clock);
        if (!reset_n) model_reset();
        g = -1;
        if (rq_v[0] && rq_v[1]) g = (m_last == 1) ? 0 : 1;
        else if (rq_v[0])       g = 0;
        else if (rq_v[1])       g = 1;

        check("p0_ready", 32'(p0_req_ready), 32'(g == 0));
        check("p1_ready", 32'(p1_req_ready), 32'(g == 1));
        check("sram_we",    32'(sram_we),    (g >= 0) ? 32'(rq_we[g])   : 32'd0);
        check("sram_wmask", 32'(sram_wmask), (g >= 0) ? 32'(rq_mask[g]) : 32'd0);
        check("sram_addr",  32'(sram_addr),  (g >= 0) ? 32'(rq_addr[g]) : 32'(m_addr));
        check("sram_din",   32'(sram_din),   (g >= 0) ? 32'(rq_din[g])  : 32'(m_din));

        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev[exp_q[0].port] = 1'b1;
            ed[exp_q[0].port] = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        check("p0_rsp_valid", 32'(p0_rsp_valid), 32'(ev[0]));
        check("p0_rsp_data",  32'(p0_rsp_data),  32'(ed[0]));
        check("p1_rsp_valid", 32'(p1_rsp_valid), 32'(ev[1]));
        check("p1_rsp_data",  32'(p1_rsp_data),  32'(ed[1]));

`ifdef SRAM_ARB_STATS_EN
        check("stat_p0", 32'(stat_p0_grants), 32'(m_g0));
        check("stat_p1", 32'(stat_p1_grants), 32'(m_g1));
        check("stat_cf", 32'(stat_conflicts), 32'(m_conf));
`else
        check("stat_p0", 32'(stat_p0_grants), 32'd0);
        check("stat_p1", 32'(stat_p1_grants), 32'd0);
        check("stat_cf", 32'(stat_conflicts), 32'd0);
`endif

        if (reset_n) begin
            if (rq_v[0] && rq_v[1]) m_conf = sat(m_conf);
            if (g >= 0) begin
                m_last = g;
                m_addr = rq_addr[g];
                m_din  = rq_din[g];
                if (g == 0) m_g0 = sat(m_g0);
                else        m_g1 = sat(m_g1);
                if (rq_we[g]) shadow[rq_addr[g]] = merge(shadow[rq_addr[g]], rq_din[g], rq_mask[g]);
                else          exp_q.push_back('{cyc + int'(RL), g, shadow[rq_addr[g]]});
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (reset_n && g >= 0) rq_v[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 2**AW; i++) shadow[i] = '0;
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b0; rq_we[p] = 1'b0; rq_mask[p] = '0; rq_addr[p] = '0; rq_din[p] = '0;
        end
        model_reset();
        #2;
        idle(2);
        reset_n = 1'b1;

        // write then read back on port 0
        set_req(0, 1'b1, 2'b11, 6'd5, 4'hA);
        step();
        set_req(0, 1'b0, 2'b00, 6'd5, 4'h0);
        step();
        idle(3);

        // preload, then reads from alternating ports on consecutive cycles
        set_req(0, 1'b1, 2'b11, 6'd1, 4'h3);
        step();
        set_req(1, 1'b1, 2'b11, 6'd2, 4'hC);
        step();
        set_req(0, 1'b0, 2'b00, 6'd1, 4'h0);
        set_req(1, 1'b0, 2'b00, 6'd2, 4'h0);
        idle(5);

        // both ports continuously valid: strict alternation
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < 2; p++)
                if (!rq_v[p]) set_req(p, 1'b0, 2'b00, AW'($urandom_range(0, 15)), 4'h0);
            step();
        end
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        idle(3);

        // access addr 9 then sit idle: address must not toggle
        set_req(1, 1'b1, 2'b01, 6'd9, 4'h6);
        step();
        idle(4);

        // reset one cycle after a read is accepted: in-flight read is dropped
        set_req(0, 1'b0, 2'b00, 6'd5, 4'h0);
        step();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(4);

        // randomized contention
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++)
                if (!rq_v[p] && $urandom_range(0, 99) < 60)
                    set_req(p, 1'($urandom_range(0, 1)), MW'($urandom),
                            AW'($urandom_range(0, 15)), DW'($urandom));
            step();
        end
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        idle(RL + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
